// File: rtl/uart_rx_buffer_if.sv
// Frame-capture and reader handshake bundle between the UART receiver,
// the receive buffer and the bus-side reader.
interface uart_rx_buffer_if;
  logic        rx_done;
  logic [15:0] rx_data;
  logic        rx_err;
  logic [3:0]  data_num;
  logic        rd_valid;
  logic        rd_ready;
  logic [15:0] rd_data;
  logic        rd_err;

  modport master (
    output rx_done, rx_data, rx_err, data_num, rd_ready,
    input  rd_valid, rd_data, rd_err
  );

  modport slave (
    input  rx_done, rx_data, rx_err, data_num, rd_ready,
    output rd_valid, rd_data, rd_err
  );
endinterface

// File: rtl/uart_rx_buffer.sv
// UART receive buffer: first-word-fall-through FIFO of received frames with
// fill level, sticky overflow, level-threshold and idle-timeout interrupts.
module uart_rx_buffer #(
  parameter int DEPTH       = 16,
  parameter int AW          = $clog2(DEPTH),
  parameter int TIMEOUT_CYC = 1000
) (
  input  logic            clk,
  input  logic            rstn,
  uart_rx_buffer_if.slave bus,
  input  logic            flush,
  output logic [AW:0]     level,
  output logic            full,
  output logic            empty,
  input  logic [AW:0]     thresh,
  output logic            ovf_flag,
  input  logic            ovf_clr,
  output logic            irq_thresh,
  output logic            irq_timeout
);

  localparam logic [AW:0] LVL_FULL = (AW + 1)'(DEPTH);

  logic [16:0]   mem [DEPTH];
  logic [AW-1:0] wr_ptr;
  logic [AW-1:0] rd_ptr;
  logic          rx_done_d;
  logic          push;
  logic          pop;
  logic          wr_en;
  logic          ovf_set;
  logic [15:0]   mask;

  // A frame is pushed once per rising edge of rx_done; a pop frees a slot in the same cycle.
  assign push    = bus.rx_done & ~rx_done_d;
  assign pop     = ~empty & bus.rd_ready;
  assign wr_en   = push & (~full | pop);
  assign ovf_set = push & full & ~pop & ~flush;
  assign mask    = 16'hFFFF >> (4'd15 - bus.data_num);

  assign full         = (level == LVL_FULL);
  assign empty        = (level == '0);
  assign bus.rd_valid = ~empty;
  assign bus.rd_data  = empty ? 16'h0000 : mem[rd_ptr][15:0];
  assign bus.rd_err   = ~empty & mem[rd_ptr][16];
  assign irq_thresh   = (thresh != '0) & (level >= thresh);

  always_ff @(posedge clk) begin
    if (wr_en & ~flush)
      mem[wr_ptr] <= {bus.rx_err, bus.rx_data & mask};
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      wr_ptr    <= '0;
      rd_ptr    <= '0;
      level     <= '0;
      rx_done_d <= 1'b0;
      ovf_flag  <= 1'b0;
    end else begin
      rx_done_d <= bus.rx_done;
      if (ovf_set)
        ovf_flag <= 1'b1;
      else if (ovf_clr)
        ovf_flag <= 1'b0;
      if (flush) begin
        wr_ptr <= '0;
        rd_ptr <= '0;
        level  <= '0;
      end else begin
        if (wr_en)
          wr_ptr <= wr_ptr + AW'(1);
        if (pop)
          rd_ptr <= rd_ptr + AW'(1);
        if (wr_en && !pop)
          level <= level + (AW + 1)'(1);
        else if (!wr_en && pop)
          level <= level - (AW + 1)'(1);
      end
    end
  end

  generate
    if (TIMEOUT_CYC > 0) begin : g_timeout
      localparam int            CW   = $clog2(TIMEOUT_CYC + 1);
      localparam logic [CW-1:0] TMAX = CW'(TIMEOUT_CYC);

      logic [CW-1:0] idle_cnt;

      // Any FIFO activity restarts the idle count; the interrupt holds until the next activity.
      always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
          idle_cnt    <= '0;
          irq_timeout <= 1'b0;
        end else begin
          if (flush || push || pop || empty)
            idle_cnt <= '0;
          else if (idle_cnt != TMAX)
            idle_cnt <= idle_cnt + CW'(1);
          if (flush || push || pop)
            irq_timeout <= 1'b0;
          else
            irq_timeout <= (idle_cnt == TMAX) & ~empty;
        end
      end
    end else begin : g_no_timeout
      assign irq_timeout = 1'b0;
    end
  endgenerate

endmodule

// File: tb/tb_uart_rx_buffer.sv
// Self-checking bench for uart_rx_buffer: table-driven vectors with a data
// scoreboard, plus hand-written timeout, flush and mid-operation reset sequences.
module tb_uart_rx_buffer;
  localparam int DEPTH = 16;

  typedef struct {
    logic        done;
    logic [15:0] data;
    logic        err;
    logic [3:0]  num;
    logic        ready;
    logic        fl;
    logic        clr;
    logic [4:0]  thr;
    int          exp_level;
    logic        exp_ovf;
    logic        exp_irq;
  } vec_t;

  logic       clk = 1'b0;
  logic       rstn;
  logic       flush;
  logic       ovf_clr;
  logic [4:0] thresh;
  logic [4:0] level;
  logic       full;
  logic       empty;
  logic       ovf_flag;
  logic       irq_thresh;
  logic       irq_timeout;

  uart_rx_buffer_if bus ();

  uart_rx_buffer #(.DEPTH(16), .AW(4), .TIMEOUT_CYC(1000)) dut (
    .clk        (clk),
    .rstn       (rstn),
    .bus        (bus),
    .flush      (flush),
    .level      (level),
    .full       (full),
    .empty      (empty),
    .thresh     (thresh),
    .ovf_flag   (ovf_flag),
    .ovf_clr    (ovf_clr),
    .irq_thresh (irq_thresh),
    .irq_timeout(irq_timeout)
  );

  always #5 clk = ~clk;

  vec_t        vecs[$];
  logic [16:0] sb[$];
  int          n_cmp = 0;
  int          n_fail = 0;
  int          prev_level = 0;
  logic        prev_done = 1'b0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  function automatic vec_t mk(input logic done, input logic [15:0] data, input logic err,
                              input logic [3:0] num, input logic ready, input logic fl,
                              input logic clr, input logic [4:0] thr, input int lvl,
                              input logic ovf, input logic irq);
    vec_t v;
    v.done = done; v.data = data; v.err = err; v.num = num; v.ready = ready;
    v.fl = fl; v.clr = clr; v.thr = thr; v.exp_level = lvl; v.exp_ovf = ovf; v.exp_irq = irq;
    return v;
  endfunction

  function automatic logic [16:0] frame(input vec_t v);
    logic [15:0] m;
    for (int b = 0; b < 16; b++)
      m[b] = (b <= int'(v.num));
    return {v.err, v.data & m};
  endfunction

  // Drive one row at the falling edge; check the head entry before the rising edge consumes it.
  task automatic applyStimulus(input vec_t v);
    logic [16:0] exp_word;
    @(negedge clk);
    bus.rx_done  = v.done;
    bus.rx_data  = v.data;
    bus.rx_err   = v.err;
    bus.data_num = v.num;
    bus.rd_ready = v.ready;
    flush        = v.fl;
    ovf_clr      = v.clr;
    thresh       = v.thr;
    #1;
    check("rd_valid", 32'(bus.rd_valid), 32'(prev_level > 0));
    if (v.ready && prev_level > 0) begin
      if (sb.size() == 0) begin
        check("sb_underflow", 32'(sb.size()), 32'd1);
      end else begin
        exp_word = sb.pop_front();
        check("rd_data", 32'(bus.rd_data), 32'(exp_word[15:0]));
        check("rd_err", 32'(bus.rd_err), 32'(exp_word[16]));
      end
    end
    if (v.fl)
      sb.delete();
    else if (v.done && !prev_done && (prev_level < DEPTH || (v.ready && prev_level > 0)))
      sb.push_back(frame(v));
    prev_done = v.done;
  endtask

  task automatic checkOutput(input vec_t v);
    @(posedge clk);
    #1;
    check("level", 32'(level), 32'(v.exp_level));
    check("full", 32'(full), 32'(v.exp_level == DEPTH));
    check("empty", 32'(empty), 32'(v.exp_level == 0));
    check("ovf_flag", 32'(ovf_flag), 32'(v.exp_ovf));
    check("irq_thresh", 32'(irq_thresh), 32'(v.exp_irq));
    prev_level = v.exp_level;
  endtask

  task automatic runRow(input vec_t v);
    applyStimulus(v);
    checkOutput(v);
  endtask

  task automatic waitTimeout(input int limit, output int cycles, output logic seen);
    cycles = 0;
    seen   = 1'b0;
    while (!seen && cycles < limit) begin
      @(posedge clk);
      #1;
      cycles++;
      seen = irq_timeout;
    end
  endtask

  initial begin
    #1ms;
    $display("[TB] FAIL watchdog: simulation time limit reached");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    int   n;
    logic seen;

    // Frame masking, pop from empty, held rx_done.
    vecs.push_back(mk(1, 16'hA5C3, 0, 7, 0, 0, 0, 0, 1, 0, 0));
    vecs.push_back(mk(0, 16'hA5C3, 0, 7, 0, 0, 0, 0, 1, 0, 0));
    vecs.push_back(mk(0, 16'h0000, 0, 7, 1, 0, 0, 0, 0, 0, 0));
    vecs.push_back(mk(0, 16'h0000, 0, 0, 1, 0, 0, 0, 0, 0, 0));
    for (int i = 0; i < 10; i++)
      vecs.push_back(mk(1, 16'h0055, 0, 15, 0, 0, 0, 0, 1, 0, 0));
    vecs.push_back(mk(0, 16'h0055, 0, 15, 0, 0, 0, 0, 1, 0, 0));
    vecs.push_back(mk(0, 16'h0000, 0, 15, 1, 0, 0, 0, 0, 0, 0));
    // Fill to full, overflow, drain in order, clear overflow.
    for (int i = 1; i <= 16; i++) begin
      vecs.push_back(mk(1, 16'(i), 1'(i % 2), 15, 0, 0, 0, 0, i, 0, 0));
      vecs.push_back(mk(0, 16'(i), 1'(i % 2), 15, 0, 0, 0, 0, i, 0, 0));
    end
    vecs.push_back(mk(1, 16'h0011, 1, 15, 0, 0, 0, 0, 16, 1, 0));
    vecs.push_back(mk(0, 16'h0011, 1, 15, 0, 0, 0, 0, 16, 1, 0));
    for (int i = 15; i >= 0; i--)
      vecs.push_back(mk(0, 16'h0000, 0, 15, 1, 0, 0, 0, i, 1, 0));
    vecs.push_back(mk(0, 16'h0000, 0, 15, 0, 0, 1, 0, 0, 0, 0));
    // Refill with varying frame lengths; overflow set beats clear; push+pop while full.
    for (int i = 1; i <= 16; i++) begin
      vecs.push_back(mk(1, 16'hF0A0 | 16'(i), 1'((i + 1) % 2), 4'(i - 1), 0, 0, 0, 0, i, 0, 0));
      vecs.push_back(mk(0, 16'hF0A0 | 16'(i), 1'((i + 1) % 2), 4'(i - 1), 0, 0, 0, 0, i, 0, 0));
    end
    vecs.push_back(mk(1, 16'h1234, 0, 15, 0, 0, 1, 0, 16, 1, 0));
    vecs.push_back(mk(0, 16'h1234, 0, 15, 0, 0, 1, 0, 16, 0, 0));
    vecs.push_back(mk(1, 16'h0077, 0, 15, 1, 0, 0, 0, 16, 0, 0));
    vecs.push_back(mk(0, 16'h0077, 0, 15, 0, 0, 0, 0, 16, 0, 0));
    for (int i = 15; i >= 0; i--)
      vecs.push_back(mk(0, 16'h0000, 0, 15, 1, 0, 0, 0, i, 0, 0));
    // Level threshold, including equality, out-of-range and disabled thresholds.
    for (int i = 1; i <= 4; i++) begin
      vecs.push_back(mk(1, 16'(i * 16'h1111), 0, 15, 0, 0, 0, 5'd4, i, 0, i >= 4));
      vecs.push_back(mk(0, 16'(i * 16'h1111), 0, 15, 0, 0, 0, 5'd4, i, 0, i >= 4));
    end
    vecs.push_back(mk(0, 16'h0000, 0, 15, 1, 0, 0, 5'd4, 3, 0, 0));
    vecs.push_back(mk(0, 16'h0000, 0, 15, 0, 0, 0, 5'd20, 3, 0, 0));
    vecs.push_back(mk(0, 16'h0000, 0, 15, 0, 0, 0, 5'd3, 3, 0, 1));
    vecs.push_back(mk(0, 16'h0000, 0, 15, 0, 0, 0, 5'd0, 3, 0, 0));
    for (int i = 2; i >= 0; i--)
      vecs.push_back(mk(0, 16'h0000, 0, 15, 1, 0, 0, 5'd0, i, 0, 0));

    rstn = 1'b0;
    bus.rx_done = 1'b0; bus.rx_data = '0; bus.rx_err = 1'b0; bus.data_num = '0;
    bus.rd_ready = 1'b0; flush = 1'b0; ovf_clr = 1'b0; thresh = '0;
    repeat (3) @(posedge clk);
    #1;
    check("reset_level", 32'(level), 32'd0);
    check("reset_empty", 32'(empty), 32'd1);
    check("reset_full", 32'(full), 32'd0);
    check("reset_rd_valid", 32'(bus.rd_valid), 32'd0);
    check("reset_rd_data", 32'(bus.rd_data), 32'd0);
    check("reset_rd_err", 32'(bus.rd_err), 32'd0);
    check("reset_ovf", 32'(ovf_flag), 32'd0);
    check("reset_irq_thresh", 32'(irq_thresh), 32'd0);
    check("reset_irq_timeout", 32'(irq_timeout), 32'd0);
    @(negedge clk);
    rstn = 1'b1;

    foreach (vecs[k])
      runRow(vecs[k]);

    // Idle timeout: the count starts on the first idle edge after the push and the
    // interrupt is registered one edge after the count saturates at 1000.
    runRow(mk(1, 16'h0123, 0, 15, 0, 0, 0, 0, 1, 0, 0));
    runRow(mk(0, 16'h0123, 0, 15, 0, 0, 0, 0, 1, 0, 0));
    check("timeout_early", 32'(irq_timeout), 32'd0);
    waitTimeout(1100, n, seen);
    check("timeout_cycles", 32'(n + 1), 32'd1001);
    check("timeout_level", 32'(level), 32'd1);
    runRow(mk(0, 16'h0000, 0, 15, 1, 0, 0, 0, 0, 0, 0));
    check("timeout_clear_pop", 32'(irq_timeout), 32'd0);

    // Overflow, timeout on a full FIFO, then flush colliding with a push.
    for (int i = 1; i <= 17; i++) begin
      runRow(mk(1, 16'h0A00 | 16'(i), 0, 15, 0, 0, 0, 0, (i > 16) ? 16 : i, i > 16, 0));
      runRow(mk(0, 16'h0A00 | 16'(i), 0, 15, 0, 0, 0, 0, (i > 16) ? 16 : i, i > 16, 0));
    end
    waitTimeout(1100, n, seen);
    check("timeout_full_seen", 32'(seen), 32'd1);
    runRow(mk(1, 16'h0BAD, 0, 15, 0, 1, 0, 0, 0, 1, 0));
    check("flush_clears_timeout", 32'(irq_timeout), 32'd0);
    runRow(mk(0, 16'h0BAD, 0, 15, 0, 0, 0, 0, 0, 1, 0));

    // Asynchronous reset with data held and overflow set.
    runRow(mk(1, 16'h00C0, 1, 15, 0, 0, 0, 0, 1, 1, 0));
    runRow(mk(0, 16'h00C0, 1, 15, 0, 0, 0, 0, 1, 1, 0));
    @(negedge clk);
    #2;
    rstn = 1'b0;
    #1;
    check("async_reset_level", 32'(level), 32'd0);
    check("async_reset_rd_valid", 32'(bus.rd_valid), 32'd0);
    check("async_reset_rd_data", 32'(bus.rd_data), 32'd0);
    check("async_reset_ovf", 32'(ovf_flag), 32'd0);
    @(negedge clk);
    rstn = 1'b1;
    sb.delete();
    prev_level = 0;
    prev_done  = 1'b0;
    runRow(mk(1, 16'h0321, 0, 15, 0, 0, 0, 0, 1, 0, 0));
    runRow(mk(0, 16'h0000, 0, 15, 1, 0, 0, 0, 0, 0, 0));

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end
endmodule
